apb_gpio_irq: RTL and testbench

Parametrised APB3 GPIO peripheral: GPIO_W tri-state pins with per-pin direction, atomic set/clear of output data, metastability-safe input sampling, and per-pin rising/falling edge interrupts collected into one level `irq` line. It sits on the APB bus as a slave next to the other peripherals, and `irq` goes to the platform interrupt input.

---
 rtl/gpio_pkg.sv | 22 ++
 rtl/gpio_pad_bank.sv | 47 ++++
 rtl/apb_gpio_irq.sv | 144 ++++++++++++++
 tb/tb_apb_gpio_irq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register map, limits and APB FSM states for apb_gpio_irq
package gpio_pkg;

    localparam int GPIO_W_MAX = 32;

    typedef enum logic [2:0] {
        GPIO_CR      = 3'd0,
        GPIO_ODR     = 3'd1,
        GPIO_IDR     = 3'd2,
        GPIO_SET     = 3'd3,
        GPIO_CLR     = 3'd4,
        GPIO_RISE_EN = 3'd5,
        GPIO_FALL_EN = 3'd6,
        GPIO_ISR     = 3'd7
    } gpio_reg_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

endpackage

// File: rtl/gpio_pad_bank.sv
// rtl/gpio_pad_bank.sv - tri-state pad drivers, input synchroniser and prev flops (prev only with GPIO_IRQ_EN)
module gpio_pad_bank
    import gpio_pkg::*;
#(
    parameter int GPIO_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [GPIO_W-1:0] cr,
    input  logic [GPIO_W-1:0] odr,
    inout  wire  [GPIO_W-1:0] gpio,
    output logic [GPIO_W-1:0] sync
`ifdef GPIO_IRQ_EN
    ,
    output logic [GPIO_W-1:0] prev
`endif
);

    logic [SYNC_STAGES-1:0][GPIO_W-1:0] chain;

    for (genvar i = 0; i < GPIO_W; i++) begin : g_pad
        assign gpio[i] = cr[i] ? odr[i] : 1'bz;
    end

    // Every pin is sampled, so output pins read back their own drive.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], gpio};
        end
    end

    assign sync = chain[SYNC_STAGES-1];

`ifdef GPIO_IRQ_EN
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            prev <= '0;
        end else begin
            prev <= sync;
        end
    end
`endif

endmodule

// File: rtl/apb_gpio_irq.sv
// rtl/apb_gpio_irq.sv - APB3 GPIO slave with edge interrupts; GPIO_IRQ_EN enables the interrupt logic
module apb_gpio_irq
    import gpio_pkg::*;
#(
    parameter int GPIO_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [4:0]        PADDR,
    input  logic              PWRITE,
    input  logic              PENABLE,
    input  logic [31:0]       PWDATA,
    input  logic              PSEL,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              irq,
    inout  wire  [GPIO_W-1:0] gpio
);

    apb_state_e        state, state_n;
    gpio_reg_e         reg_sel;
    logic              xfer;
    logic              wr_en;
    logic [GPIO_W-1:0] wdata;
    logic [GPIO_W-1:0] cr, odr, sync;
    logic [31:0]       rdata;
    logic              unused_bits;
`ifdef GPIO_IRQ_EN
    logic [GPIO_W-1:0] prev, rise_en, fall_en, isr, hit;
`endif

    assign reg_sel     = gpio_reg_e'(PADDR[4:2]);
    assign wdata       = PWDATA[GPIO_W-1:0];
    assign wr_en       = xfer & PWRITE;
    assign unused_bits = ^{PADDR[1:0], PWDATA};

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        xfer    = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && PENABLE && !PREADY) begin
                    xfer    = 1'b1;
                    state_n = ACCESS;
                end
            end
            ACCESS:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            cr  <= '0;
            odr <= '0;
        end else if (wr_en) begin
            case (reg_sel)
                GPIO_CR:  cr  <= wdata;
                GPIO_ODR: odr <= wdata;
                GPIO_SET: odr <= odr | wdata;
                GPIO_CLR: odr <= odr & ~wdata;
                default:  ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            GPIO_CR:      rdata = 32'(cr);
            GPIO_ODR:     rdata = 32'(odr);
            GPIO_IDR:     rdata = 32'(sync);
`ifdef GPIO_IRQ_EN
            GPIO_RISE_EN: rdata = 32'(rise_en);
            GPIO_FALL_EN: rdata = 32'(fall_en);
            GPIO_ISR:     rdata = 32'(isr);
`endif
            default:      rdata = '0;
        endcase
    end

    // PRDATA only changes on read completions; PSLVERR flags IDR writes.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            PREADY  <= xfer;
            PSLVERR <= wr_en && (reg_sel == GPIO_IDR);
            if (xfer && !PWRITE) begin
                PRDATA <= rdata;
            end
        end
    end

    gpio_pad_bank #(
        .GPIO_W      (GPIO_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pad_bank (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .cr     (cr),
        .odr    (odr),
        .gpio   (gpio),
        .sync   (sync)
`ifdef GPIO_IRQ_EN
        ,
        .prev   (prev)
`endif
    );

`ifdef GPIO_IRQ_EN
    assign hit = (sync & ~prev & rise_en) | (~sync & prev & fall_en);

    // A new edge overrides a simultaneous write-1-to-clear.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            rise_en <= '0;
            fall_en <= '0;
            isr     <= '0;
        end else begin
            if (wr_en && reg_sel == GPIO_RISE_EN) rise_en <= wdata;
            if (wr_en && reg_sel == GPIO_FALL_EN) fall_en <= wdata;
            isr <= ((wr_en && reg_sel == GPIO_ISR) ? (isr & ~wdata) : isr) | hit;
        end
    end

    assign irq = |isr;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_apb_gpio_irq.sv
// tb/tb_apb_gpio_irq.sv - self-checking bench for apb_gpio_irq against a register-level model
module tb_apb_gpio_irq;

`ifdef GPIO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [4:0]  PADDR;
    logic        PWRITE;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        irq;
    wire  [7:0]  gpio;

    logic [7:0]  tb_en;
    logic [7:0]  tb_val;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] m_cr, m_odr, m_rise, m_fall, m_isr, m_pad;
    logic       irq_ready;

    always #5 PCLK = ~PCLK;

    for (genvar i = 0; i < 8; i++) begin : g_drv
        assign gpio[i] = tb_en[i] ? tb_val[i] : 1'bz;
    end

    apb_gpio_irq dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PADDR   (PADDR),
        .PWRITE  (PWRITE),
        .PENABLE (PENABLE),
        .PWDATA  (PWDATA),
        .PSEL    (PSEL),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .irq     (irq),
        .gpio    (gpio)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pad_now();
        return (m_cr & m_odr) | (~m_cr & tb_val);
    endfunction

    task automatic model_reset();
        m_cr = '0; m_odr = '0; m_rise = '0; m_fall = '0; m_isr = '0;
        m_pad = pad_now();
    endtask

    task automatic model_settle();
        logic [7:0] now;
        now   = pad_now();
        m_isr = m_isr | (now & ~m_pad & m_rise) | (~now & m_pad & m_fall);
        m_pad = now;
    endtask

    task automatic model_write(input int idx, input logic [7:0] w);
        case (idx)
            0: m_cr = w;
            1: m_odr = w;
            3: m_odr = m_odr | w;
            4: m_odr = m_odr & ~w;
            5: if (IRQ_EN) m_rise = w;
            6: if (IRQ_EN) m_fall = w;
            7: m_isr = m_isr & ~w;
            default: ;
        endcase
        model_settle();
    endtask

    function automatic logic [31:0] model_read(input int idx);
        case (idx)
            0: return {24'h0, m_cr};
            1: return {24'h0, m_odr};
            2: return {24'h0, m_pad};
            5: return {24'h0, m_rise};
            6: return {24'h0, m_fall};
            7: return {24'h0, m_isr};
            default: return 32'h0;
        endcase
    endfunction

    task automatic apb_xfer(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err);
        int n;
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        @(negedge PCLK);
        PENABLE = 1'b1;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!PREADY && n < 8);
        check("access_len", n, 1);
        rd = PRDATA; err = PSLVERR; irq_ready = irq;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        check("pready_pulse", PREADY, 1'b0);
        repeat (3) @(negedge PCLK);
    endtask

    task automatic do_write(input int idx, input logic [31:0] w);
        logic [31:0] rd;
        logic        err;
        logic [4:0]  addr;
        addr = 5'(idx << 2) | 5'($urandom_range(0, 3));
        apb_xfer(1'b1, addr, w, rd, err);
        check($sformatf("wr_err[%0d]", idx), err, (idx == 2) ? 1 : 0);
        model_write(idx, w[7:0]);
    endtask

    task automatic do_read(input int idx);
        logic [31:0] rd;
        logic        err;
        apb_xfer(1'b0, 5'(idx << 2), $urandom, rd, err);
        check($sformatf("rd[%0d]", idx), rd, model_read(idx));
        check($sformatf("rd_err[%0d]", idx), err, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [7:0]  new_cr;

        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; tb_en = 8'hFF; tb_val = 8'h5A;
        repeat (3) @(negedge PCLK);
        check("rst_pready", PREADY, 1'b0);
        check("rst_pslverr", PSLVERR, 1'b0);
        check("rst_prdata", PRDATA, 32'h0);
        check("rst_irq", irq, 1'b0);
        PRESET = 1'b1;
        model_reset();
        repeat (5) @(negedge PCLK);
        check("rst_gpio_z", {24'h0, gpio}, 32'h5A);
        check("idle_pready", PREADY, 1'b0);
        for (int i = 0; i < 8; i++) do_read(i);

        // Output data path: write, atomic set and clear
        tb_en = 8'h00;
        do_write(0, 32'hFF);
        do_write(1, 32'hA5);
        check("gpio_odr", {24'h0, gpio}, 32'hA5);
        do_write(3, 32'h0A);
        check("gpio_set", {24'h0, gpio}, 32'hAF);
        do_write(4, 32'h81);
        check("gpio_clr", {24'h0, gpio}, 32'h2E);
        do_read(2);
        do_read(3);
        do_read(4);

        // Back to inputs driven by the bench
        do_write(0, 32'h0);
        tb_en = 8'hFF; tb_val = 8'h80;
        repeat (5) @(negedge PCLK);
        model_settle();
        do_read(2);

        // IDR write errors; ISR read has no error and reads the model value
        do_write(2, 32'hFF);
        do_read(7);

`ifdef GPIO_IRQ_EN
        do_write(5, 32'h01);
        @(negedge PCLK);
        tb_val[0] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge PCLK);
            #1;
            check($sformatf("irq_lat%0d", k), irq, (k == 3) ? 1 : 0);
        end
        model_settle();
        do_read(7);
        do_write(7, 32'h01);
        check("irq_w1c", irq_ready, 1'b0);
        do_read(7);

        do_write(6, 32'h80);
        @(negedge PCLK);
        tb_val[7] = 1'b0;
        apb_xfer(1'b1, 5'h1C, 32'h80, rd, err);
        check("w1c_err", err, 1'b0);
        model_write(7, 8'h80);
        do_read(7);
        check("irq_set_wins", irq, 1'b1);
        do_write(6, 32'h0);
        do_read(7);
        do_write(7, 32'h80);
        check("irq_cleared", irq, 1'b0);
`endif

        // Randomised phase with a fixed direction mask
        do_write(5, 32'h0);
        do_write(6, 32'h0);
        new_cr = 8'($urandom);
        tb_en  = tb_en & ~new_cr;
        do_write(0, {24'h0, new_cr});
        tb_en  = ~new_cr;
        tb_val = 8'($urandom);
        repeat (5) @(negedge PCLK);
        model_settle();
        do_write(7, 32'hFF);
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    do_write($urandom_range(1, 7), $urandom);
                    check("rnd_irq_w", irq, |m_isr);
                end
                1: do_read($urandom_range(0, 7));
                default: begin
                    tb_val = 8'($urandom);
                    repeat (5) @(negedge PCLK);
                    model_settle();
                    check("rnd_gpio", {24'h0, gpio & m_cr}, {24'h0, m_odr & m_cr});
                    check("rnd_irq", irq, |m_isr);
                end
            endcase
        end

        // Reset during the access phase of an ODR write
        do_write(1, 32'h0);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h04; PWDATA = 32'hFF;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1;
        PRESET = 1'b0;
        #1;
        check("rst_mid_pready", PREADY, 1'b0);
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        tb_en = 8'hFF;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b1;
        model_reset();
        repeat (5) @(negedge PCLK);
        check("rst_mid_pready2", PREADY, 1'b0);
        check("rst_mid_irq", irq, 1'b0);
        do_read(1);
        do_read(0);
        do_read(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
